// File: rtl/vc_dest_arbiter_pkg.sv
// Shared state encoding and destination constants for vc_dest_arbiter.
package vc_dest_arbiter_pkg;

  localparam int DEST_BITS = 2;
  localparam int NUM_DEST  = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    POP  = 3'd1,
    CAP  = 3'd2,
    HOLD = 3'd3,
    PUSH = 3'd4
  } arb_state_t;

  function automatic logic [NUM_DEST-1:0] dest_onehot(input logic [DEST_BITS-1:0] dest);
    logic [NUM_DEST-1:0] v;
    v       = '0;
    v[dest] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/vc_dest_arbiter_rr_arb2.sv
// Two-requester grant function: round-robin by default, VC0-first when
// ARB_STRICT_PRIO_EN is defined.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       valid
);

  assign valid = |req;

`ifdef ARB_STRICT_PRIO_EN
  logic unused_last;
  assign unused_last = last_grant;
  assign grant       = ~req[0];
`else
  // Prefer the requester that did not win last time, else fall back to the other.
  assign grant = req[~last_grant] ? ~last_grant : last_grant;
`endif

endmodule

// File: rtl/vc_dest_arbiter.sv
// Moves words from two VC FIFOs to four destination FIFOs, one word in flight.
// Optional macro ARB_STRICT_PRIO_EN selects strict VC0 priority instead of round-robin.
module vc_dest_arbiter
  import vc_dest_arbiter_pkg::*;
#(
  parameter int DATA_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 vc0_empty,
  input  logic                 vc1_empty,
  input  logic [DATA_SIZE-1:0] vc0_data,
  input  logic [DATA_SIZE-1:0] vc1_data,
  input  logic [NUM_DEST-1:0]  d_pause,
  input  logic [NUM_DEST-1:0]  d_full,
  output logic                 vc0_pop,
  output logic                 vc1_pop,
  output logic [NUM_DEST-1:0]  d_push,
  output logic [DATA_SIZE-1:0] d_data,
  output logic                 busy,
  output logic                 last_grant
);

  arb_state_t               state, state_nxt;
  logic                     vc0_pop_nxt, vc1_pop_nxt, last_grant_nxt;
  logic [NUM_DEST-1:0]      d_push_nxt;
  logic [DATA_SIZE-1:0]     d_data_nxt;
  logic [DATA_SIZE-1:0]     hold_word;
  logic [DATA_SIZE-1:0]     cap_word;
  logic [DEST_BITS-1:0]     dest;
  logic                     dest_blocked;
  logic                     arb_grant, arb_valid;

  rr_arb2 u_arb (
    .req        ({~vc1_empty, ~vc0_empty}),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .valid      (arb_valid)
  );

  // In CAP the popped word is on the granted VC's data bus; afterwards it lives in hold_word.
  assign cap_word     = (state == CAP) ? (last_grant ? vc1_data : vc0_data) : hold_word;
  assign dest         = cap_word[DATA_SIZE-1 -: DEST_BITS];
  assign dest_blocked = d_pause[dest] | d_full[dest];
  assign busy         = (state != IDLE);

  always_comb begin
    state_nxt      = state;
    vc0_pop_nxt    = 1'b0;
    vc1_pop_nxt    = 1'b0;
    d_push_nxt     = '0;
    d_data_nxt     = d_data;
    last_grant_nxt = last_grant;
    case (state)
      IDLE, PUSH: begin
        state_nxt = IDLE;
        if (arb_valid) begin
          state_nxt      = POP;
          last_grant_nxt = arb_grant;
          vc0_pop_nxt    = ~arb_grant;
          vc1_pop_nxt    = arb_grant;
        end
      end
      POP:
        state_nxt = CAP;
      CAP, HOLD: begin
        if (dest_blocked) begin
          state_nxt = HOLD;
        end else begin
          state_nxt  = PUSH;
          d_push_nxt = dest_onehot(dest);
          d_data_nxt = cap_word;
        end
      end
      default:
        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      vc0_pop    <= 1'b0;
      vc1_pop    <= 1'b0;
      d_push     <= '0;
      d_data     <= '0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nxt;
      vc0_pop    <= vc0_pop_nxt;
      vc1_pop    <= vc1_pop_nxt;
      d_push     <= d_push_nxt;
      d_data     <= d_data_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  // Holding register: pure data, only meaningful while state is HOLD.
  always_ff @(posedge clk) begin
    if (state == CAP) hold_word <= cap_word;
  end

endmodule

// File: tb/tb_vc_dest_arbiter.sv
// Self-checking bench for vc_dest_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based transaction model.
module tb_vc_dest_arbiter;

`ifdef ARB_STRICT_PRIO_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       vc0_empty, vc1_empty;
  logic [7:0] vc0_data, vc1_data;
  logic [3:0] d_pause, d_full;
  logic       vc0_pop, vc1_pop;
  logic [3:0] d_push;
  logic [7:0] d_data;
  logic       busy, last_grant;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  vc_dest_arbiter #(.DATA_SIZE(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .vc0_empty  (vc0_empty),
    .vc1_empty  (vc1_empty),
    .vc0_data   (vc0_data),
    .vc1_data   (vc1_data),
    .d_pause    (d_pause),
    .d_full     (d_full),
    .vc0_pop    (vc0_pop),
    .vc1_pop    (vc1_pop),
    .d_push     (d_push),
    .d_data     (d_data),
    .busy       (busy),
    .last_grant (last_grant)
  );

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    vc0_empty = 1'b1; vc1_empty = 1'b1;
    vc0_data = 8'h00; vc1_data = 8'h00;
    d_pause = 4'h0; d_full = 4'h0;
    @(negedge clk);
    compared++;
    if ({vc0_pop, vc1_pop} !== 2'b00) begin
      mismatched++; $display("FAIL reset_pops got=%b exp=00", {vc0_pop, vc1_pop});
    end
    compared++;
    if (d_push !== 4'h0 || d_data !== 8'h00) begin
      mismatched++; $display("FAIL reset_push got=%b/%h exp=0000/00", d_push, d_data);
    end
    compared++;
    if (last_grant !== 1'b1 || busy !== 1'b0) begin
      mismatched++; $display("FAIL reset_lg_busy got=%b/%b exp=1/0", last_grant, busy);
    end
    reset = 1'b1;
  endtask

  task automatic test_single();
    int n;
    vc0_data = 8'hC5; vc0_empty = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (vc0_pop !== 1'b1 && n < 6);
    compared++;
    if (vc0_pop !== 1'b1 || n != 1) begin
      mismatched++; $display("FAIL single_pop got=%b after %0d cycles exp=1 after 1", vc0_pop, n);
    end
    vc0_empty = 1'b1;
    @(negedge clk);
    compared++;
    if ({vc0_pop, vc1_pop, d_push} !== 6'b0 || busy !== 1'b1) begin
      mismatched++; $display("FAIL single_cap got=%b%b%b busy=%b exp=000000 busy=1", vc0_pop, vc1_pop, d_push, busy);
    end
    @(negedge clk);
    compared++;
    if (d_push !== 4'b1000 || d_data !== 8'hC5) begin
      mismatched++; $display("FAIL single_push got=%b/%h exp=1000/c5", d_push, d_data);
    end
    compared++;
    if (last_grant !== 1'b0) begin
      mismatched++; $display("FAIL single_lg got=%b exp=0", last_grant);
    end
    @(negedge clk);
    compared++;
    if (d_push !== 4'h0 || d_data !== 8'hC5 || busy !== 1'b0) begin
      mismatched++; $display("FAIL single_after got=%b/%h busy=%b exp=0000/c5 busy=0", d_push, d_data, busy);
    end
  endtask

  task automatic test_alternate();
    int  k, last_c, n;
    bit  exp_vc;
    vc0_data = 8'h02; vc1_data = 8'h81;
    vc0_empty = 1'b0; vc1_empty = 1'b0;
    d_pause = 4'h0; d_full = 4'h0;
    do_reset();
    k = 0; last_c = 0;
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      if (vc0_pop === 1'b1 || vc1_pop === 1'b1) begin
        exp_vc = STRICT ? 1'b0 : k[0];
        compared++;
        if (vc1_pop !== exp_vc || vc0_pop !== ~exp_vc) begin
          mismatched++; $display("FAIL alt_grant#%0d got=%b%b exp_vc=%0d", k, vc1_pop, vc0_pop, exp_vc);
        end
        compared++;
        if (last_grant !== exp_vc) begin
          mismatched++; $display("FAIL alt_lg#%0d got=%b exp=%b", k, last_grant, exp_vc);
        end
        if (k > 0) begin
          compared++;
          if (c - last_c != 3) begin
            mismatched++; $display("FAIL alt_spacing#%0d got=%0d exp=3", k, c - last_c);
          end
        end
        last_c = c; k++;
      end
    end
    compared++;
    if (k != 8) begin
      mismatched++; $display("FAIL alt_count got=%0d exp=8", k);
    end
    // With VC0 drained, VC1 must be served in either arbitration mode.
    vc0_empty = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (vc0_pop !== 1'b1 && vc1_pop !== 1'b1 && n < 8);
    compared++;
    if (vc1_pop !== 1'b1 || vc0_pop !== 1'b0) begin
      mismatched++; $display("FAIL alt_vc1_served got=%b%b exp=10", vc1_pop, vc0_pop);
    end
    vc1_empty = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (busy !== 1'b0 && n < 10);
    compared++;
    if (busy !== 1'b0) begin
      mismatched++; $display("FAIL alt_idle got busy=%b exp=0", busy);
    end
  endtask

  task automatic test_hold();
    int n;
    do_reset();
    vc0_data = 8'h41; d_pause = 4'b0010; d_full = 4'h0; vc0_empty = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (vc0_pop !== 1'b1 && n < 6);
    compared++;
    if (vc0_pop !== 1'b1) begin
      mismatched++; $display("FAIL hold_pop got=%b exp=1", vc0_pop);
    end
    vc0_empty = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      d_pause[0] = ~d_pause[0];
      @(negedge clk);
      compared++;
      if (d_push !== 4'h0 || {vc0_pop, vc1_pop} !== 2'b00 || busy !== 1'b1 || d_data !== 8'h00) begin
        mismatched++;
        $display("FAIL hold_cycle%0d got push=%b pops=%b%b busy=%b data=%h exp 0000/00/1/00", i, d_push, vc0_pop, vc1_pop, busy, d_data);
      end
    end
    d_pause[1] = 1'b0;
    @(negedge clk);
    compared++;
    if (d_push !== 4'b0010 || d_data !== 8'h41) begin
      mismatched++; $display("FAIL hold_release got=%b/%h exp=0010/41", d_push, d_data);
    end
    @(negedge clk);
    compared++;
    if (d_push !== 4'h0 || busy !== 1'b0) begin
      mismatched++; $display("FAIL hold_done got=%b busy=%b exp=0000 busy=0", d_push, busy);
    end
    d_pause = 4'h0;
  endtask

  task automatic test_reset_hold();
    int n;
    vc0_data = 8'h41; d_pause = 4'b0010; vc0_empty = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (vc0_pop !== 1'b1 && n < 6);
    vc0_empty = 1'b1;
    repeat (3) @(negedge clk);
    compared++;
    if (busy !== 1'b1 || d_push !== 4'h0) begin
      mismatched++; $display("FAIL rsthold_pre got busy=%b push=%b exp=1/0000", busy, d_push);
    end
    #2 reset = 1'b0;
    #1;
    compared++;
    if ({vc0_pop, vc1_pop} !== 2'b00 || d_push !== 4'h0 || d_data !== 8'h00) begin
      mismatched++; $display("FAIL rsthold_async got pops=%b%b push=%b data=%h exp 00/0000/00", vc0_pop, vc1_pop, d_push, d_data);
    end
    compared++;
    if (last_grant !== 1'b1 || busy !== 1'b0) begin
      mismatched++; $display("FAIL rsthold_lg got=%b busy=%b exp=1/0", last_grant, busy);
    end
    @(negedge clk);
    reset = 1'b1; d_pause = 4'h0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      compared++;
      if (d_push !== 4'h0 || busy !== 1'b0) begin
        mismatched++; $display("FAIL rsthold_after%0d got push=%b busy=%b exp=0000/0", i, d_push, busy);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] flight;
    logic [3:0] exp_push;
    bit         flight_vld, mdl_last, exp_vc, pref_empty;
    int         enq, pushed;
    vc0_empty = 1'b1; vc1_empty = 1'b1; d_pause = 4'h0; d_full = 4'h0;
    do_reset();
    mdl_last = 1'b1; flight_vld = 1'b0; flight = 8'h00; enq = 0; pushed = 0;
    for (int cyc = 0; cyc < 1400; cyc++) begin
      @(negedge clk);
      if (d_push !== 4'h0) begin
        compared++;
        if (!flight_vld) begin
          mismatched++; $display("FAIL rand_push_orphan got=%b exp=no push", d_push);
        end else begin
          exp_push = 4'b0001 << flight[7:6];
          compared++;
          if (d_push !== exp_push) begin
            mismatched++; $display("FAIL rand_push_dest got=%b exp=%b", d_push, exp_push);
          end
          compared++;
          if (d_data !== flight) begin
            mismatched++; $display("FAIL rand_push_data got=%h exp=%h", d_data, flight);
          end
          compared++;
          if (((d_pause | d_full) & exp_push) != 4'h0) begin
            mismatched++; $display("FAIL rand_push_blocked got pause=%b full=%b exp dest %b free", d_pause, d_full, exp_push);
          end
        end
        flight_vld = 1'b0; pushed++;
      end
      if (vc0_pop === 1'b1 || vc1_pop === 1'b1) begin
        pref_empty = mdl_last ? vc0_empty : vc1_empty;
        exp_vc     = STRICT ? vc0_empty : (pref_empty ? mdl_last : ~mdl_last);
        compared++;
        if ((vc0_pop && vc0_empty) || (vc1_pop && vc1_empty)) begin
          mismatched++; $display("FAIL rand_pop_empty got pops=%b%b empties=%b%b", vc1_pop, vc0_pop, vc1_empty, vc0_empty);
        end
        compared++;
        if (vc1_pop !== exp_vc || vc0_pop !== ~exp_vc) begin
          mismatched++; $display("FAIL rand_grant got=%b%b exp_vc=%0d", vc1_pop, vc0_pop, exp_vc);
        end
        compared++;
        if (last_grant !== exp_vc) begin
          mismatched++; $display("FAIL rand_lg got=%b exp=%b", last_grant, exp_vc);
        end
        compared++;
        if (flight_vld) begin
          mismatched++; $display("FAIL rand_overlap got second pop exp one word in flight");
        end
        mdl_last = exp_vc;
        if (vc1_pop === 1'b1) begin
          if (q1.size() > 0) begin flight = q1.pop_front(); vc1_data = flight; end
        end else begin
          if (q0.size() > 0) begin flight = q0.pop_front(); vc0_data = flight; end
        end
        flight_vld = 1'b1;
      end
      if (cyc < 700) begin
        if ($urandom_range(0, 9) == 0) begin q0.push_back(8'($urandom)); enq++; end
        if ($urandom_range(0, 9) == 0) begin q1.push_back(8'($urandom)); enq++; end
        d_pause = 4'($urandom & $urandom);
        d_full  = 4'($urandom & $urandom & $urandom);
      end else begin
        d_pause = 4'h0; d_full = 4'h0;
      end
      vc0_empty = (q0.size() == 0);
      vc1_empty = (q1.size() == 0);
      if (cyc >= 700 && q0.size() == 0 && q1.size() == 0 && !flight_vld && busy === 1'b0) break;
    end
    compared++;
    if (pushed != enq || q0.size() != 0 || q1.size() != 0 || flight_vld) begin
      mismatched++; $display("FAIL rand_drain got pushed=%0d left=%0d/%0d exp pushed=%0d left=0/0", pushed, q0.size(), q1.size(), enq);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_hold();
    test_reset_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
